ws_arbiter: RTL
===============

WS_ARBITER -- requirements
Module: ws_arbiter

Interface
REQ-001 Parameter READ_STAGES, default 3: wait-state count for read cycles (0..15).
REQ-002 Parameter WRITE_STAGES, default 0: wait-state count for write cycles (0..15).
REQ-003 Parameter ACK_LEVEL, default 1'b0: value driven on both ack_o outputs whenever acknowledge is not being asserted.
REQ-004 Port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 Port ce_i, input, 1: clock enable; gates the wait-state counter only.
REQ-007 Ports m0_cyc_i, m0_stb_i, m0_we_i, input, 1 each: requester 0 bus cycle, strobe and write flag.
REQ-008 Ports m1_cyc_i, m1_stb_i, m1_we_i, input, 1 each: requester 1 equivalents.
REQ-009 Ports m0_ack_o, m1_ack_o, output, 1 each: per-requester acknowledge.
REQ-010 Port s_cyc_o, output, 1: shared slave cycle active.
REQ-011 Port s_we_o, output, 1: write flag of the granted requester.
REQ-012 Port s_gnt_o, output, 1: index of the granted requester (0 or 1).
REQ-013 Port busy_o, output, 1: high in any state other than IDLE.

Function
REQ-014 The FSM shall have exactly four states: IDLE, WAIT, ACK and RELEASE.
REQ-015 A requester requests when its cyc_i & stb_i are both high.
REQ-016 In IDLE with one request: grant that requester; with two: grant the one not marked last-served; go to WAIT.
REQ-017 On grant, latch s_gnt_o and s_we_o from the granted requester and load the counter with WRITE_STAGES if we_i=1, else READ_STAGES.
REQ-018 In WAIT, at each edge with ce_i=1: counter==0 -> ACK, otherwise counter decrements; with ce_i=0, counter and state hold.
REQ-019 Latency with ce_i held high: request sampled in IDLE at edge 0 -> ack visible after edge N+1, N = the loaded stage count (N=0 gives ack after edge 1).
REQ-020 In ACK, the granted requester's ack_o shall be 1 and the other ack_o shall be ACK_LEVEL; ACK holds while the granted requester's stb_i is high.
REQ-021 ACK -> RELEASE on the edge where the granted stb_i is sampled low.
REQ-022 RELEASE shall last exactly one cycle with no grant; last-served is set to s_gnt_o; then go to IDLE.
REQ-023 Abort: granted cyc_i sampled low in WAIT or ACK -> RELEASE; no ack is produced for that cycle.
REQ-024 s_cyc_o shall be 1 in WAIT and ACK, 0 in IDLE and RELEASE.
REQ-025 Outside ACK, both ack_o outputs shall be ACK_LEVEL.
REQ-026 ack_o outputs shall be decoded from the registered state only, with no combinational path from any input.
REQ-027 Requests from the non-granted requester shall be ignored until IDLE; they are never dropped while held.
REQ-028 Changes to the granted requester's we_i after grant shall have no effect until the next grant.
REQ-029 The counter shall be 4 bits and shall never wrap below 0.

Reset
REQ-030 On rst_i=1, asynchronously: state=IDLE, counter=0, s_gnt_o=0, s_we_o=0, last-served=1 (requester 0 wins the first tie).
REQ-031 During reset: s_cyc_o=0, busy_o=0, both ack_o=ACK_LEVEL.
REQ-032 Reset asserted mid-cycle shall abandon the cycle; no ack is issued after reset releases.

Verification
REQ-033 Read, READ_STAGES=3, ce_i=1, m0 requests at edge 0 -> m0_ack_o=1 after edge 4; held until stb drops; busy_o low two edges after stb drops.
REQ-034 Write, WRITE_STAGES=0, m1 alone -> m1_ack_o=1 after edge 1; s_we_o=1; s_gnt_o=1.
REQ-035 Both requesting continuously after reset -> grant order 0,1,0,1; one RELEASE cycle between grants.
REQ-036 READ_STAGES=3 with ce_i=0 on alternate cycles -> ack delayed to after edge 7 (counter moves on 4 enabled edges only).
REQ-037 m0 drops cyc_i in WAIT with counter=2 -> no m0_ack_o; RELEASE then IDLE; a pending m1 request is granted next.
REQ-038 rst_i pulsed in ACK -> all outputs at reset values immediately; state IDLE; no ack after release.

Source files
------------

// File: rtl/ws_arbiter.sv
// ws_arbiter: two-requester round-robin arbiter with programmable read/write wait states.
// Ack outputs are decoded from registered state only; the counter is gated by ce_i.
module ws_arbiter #(
    parameter int unsigned READ_STAGES  = 3,
    parameter int unsigned WRITE_STAGES = 0,
    parameter logic        ACK_LEVEL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce_i,
    input  logic m0_cyc_i,
    input  logic m0_stb_i,
    input  logic m0_we_i,
    input  logic m1_cyc_i,
    input  logic m1_stb_i,
    input  logic m1_we_i,
    output logic m0_ack_o,
    output logic m1_ack_o,
    output logic s_cyc_o,
    output logic s_we_o,
    output logic s_gnt_o,
    output logic busy_o
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       last;
    logic       req0, req1, pick, pick_we, g_cyc, g_stb;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    // on a tie the requester not served last wins
    assign pick    = (req0 & req1) ? ~last : req1;
    assign pick_we = pick ? m1_we_i : m0_we_i;
    assign g_cyc   = s_gnt_o ? m1_cyc_i : m0_cyc_i;
    assign g_stb   = s_gnt_o ? m1_stb_i : m0_stb_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            s_gnt_o <= 1'b0;
            s_we_o  <= 1'b0;
            last    <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    state   <= WAIT;
                    s_gnt_o <= pick;
                    s_we_o  <= pick_we;
                    cnt     <= pick_we ? 4'(WRITE_STAGES) : 4'(READ_STAGES);
                end
                WAIT: if (!g_cyc) state <= RELEASE;
                    else if (ce_i) begin
                        if (cnt == 4'd0) state <= ACK;
                        else cnt <= cnt - 4'd1;
                    end
                ACK: if (!g_cyc || !g_stb) state <= RELEASE;
                RELEASE: begin
                    last  <= s_gnt_o;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_ack_o = (state == ACK && !s_gnt_o) ? 1'b1 : ACK_LEVEL;
    assign m1_ack_o = (state == ACK &&  s_gnt_o) ? 1'b1 : ACK_LEVEL;
    assign s_cyc_o  = (state == WAIT) || (state == ACK);
    assign busy_o   = state != IDLE;
endmodule
